// File: rtl/param_mod_counter.sv
// Modulo-N up/down counter with load and wrap/saturate/one-shot modes.
// Ports: clk, rst (async, active-low), en, up_dn, load, load_val, mode,
//   start, clr_ovf -> q, tc (terminal pulse), ovf (sticky), busy.
module param_mod_counter #(
  parameter int unsigned     WIDTH     = 4,
  parameter longint unsigned MODULUS   = 16,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } st_e;

  st_e              st_q, st_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] q_step;
  logic             at_term;
  logic             ovf_set;
  logic             os_mode;
  logic             sat_mode;

  always_comb begin
    term     = up_dn ? MAX_V : '0;
    at_term  = (q_q == term);
    q_step   = up_dn ? q_q + ONE_V : q_q - ONE_V;
    os_mode  = (mode == 2'b10);
    sat_mode = (mode == 2'b01);

    q_d     = q_q;
    tc_d    = 1'b0;
    ovf_set = 1'b0;
    st_d    = st_q;

    // Leaving one-shot mode, or the single DONE cycle, always ends in IDLE.
    if (!os_mode || st_q == ST_DONE) begin
      st_d = ST_IDLE;
    end

    if (load) begin
      q_d = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (os_mode) begin
      unique case (st_q)
        ST_IDLE: begin
          if (start) begin
            q_d  = up_dn ? '0 : MAX_V;
            st_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (en) begin
            if (at_term) begin
              tc_d = 1'b1;
              st_d = ST_DONE;
            end else begin
              q_d = q_step;
            end
          end
        end
        default: begin
        end
      endcase
    end else if (en) begin
      tc_d    = at_term;
      ovf_set = at_term;
      if (!at_term) begin
        q_d = q_step;
      end else if (!sat_mode) begin
        q_d = up_dn ? '0 : MAX_V;
      end
    end

    // A same-cycle set beats clr_ovf.
    ovf_d = ovf_set | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q   <= RST_V;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
      st_q  <= ST_IDLE;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
      st_q  <= st_d;
    end
  end

  assign q    = q_q;
  assign tc   = tc_q;
  assign ovf  = ovf_q;
  assign busy = (st_q == ST_RUN);

endmodule

// File: doc/param_mod_counter.md
Name: param_mod_counter

Overview:
Parametrised successor to the 4-bit ripple-carry counter: a synchronous modulo-N up/down counter with parallel load and three counting modes (wrap, saturate, one-shot). It drives the count, a terminal-count pulse, a sticky overflow flag and a busy indicator. It is used as the general counter/timer primitive and is exercised by a stimulus module under the existing top-level bench structure.

Parameters:
WIDTH, 4, counter width in bits (2..32)
MODULUS, 16, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH
RESET_VAL, 0, value of q after reset; must be < MODULUS

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous active-low reset (0 = reset)
en  input  1  count enable; one step per cycle while high
up_dn  input  1  direction: 1 = up, 0 = down
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  load value
mode  input  2  00 = wrap, 01 = saturate, 10 = one-shot, 11 = reserved (behaves as wrap)
start  input  1  one-shot trigger (ignored in other modes)
clr_ovf  input  1  synchronous clear of ovf
q  output  WIDTH  current count, registered
tc  output  1  terminal-count pulse, registered, one cycle wide
ovf  output  1  sticky overflow/underflow flag, registered
busy  output  1  high while the one-shot FSM is in RUN

Behaviour:
- Reset (rst=0, asynchronous): q=RESET_VAL, tc=0, ovf=0, busy=0, FSM=IDLE. Release is sampled on the next rising clk edge.
- Terminal value T: MODULUS-1 when up_dn=1, 0 when up_dn=0. A boundary step is a cycle where a count step is taken while q==T.
- Per-cycle priority: load > start (one-shot IDLE only) > count step > hold.
- load=1: q <= min(load_val, MODULUS-1) next cycle. No tc or ovf that cycle. FSM state unchanged. Load wins over a simultaneous boundary step.
- Count step, non-boundary: q <= q+1 (up) or q-1 (down), modulo arithmetic kept within 0..MODULUS-1.
- Wrap mode (00/11): step when en=1. Boundary step -> q <= opposite end (0 or MODULUS-1), tc=1 next cycle, ovf <= 1.
- Saturate mode (01): step when en=1. Boundary step -> q holds at T, tc=1 next cycle, ovf <= 1. Repeats every cycle while en=1 at T.
- One-shot mode (10): FSM IDLE/RUN/DONE.
  - IDLE: q holds, busy=0. start=1 -> q <= (up_dn ? 0 : MODULUS-1), go to RUN.
  - RUN: busy=1. Step when en=1. Boundary step -> q holds at T, tc=1 next cycle, go to DONE. ovf is never set in this mode. start is ignored.
  - DONE: busy=0, q holds, one cycle only, then IDLE.
- tc is high only in the single cycle after the qualifying step; otherwise 0.
- ovf: set has priority over a same-cycle clr_ovf. clr_ovf otherwise clears it next cycle.
- Mode change: mode is sampled every cycle. Leaving 10 while in RUN or DONE forces IDLE and busy=0 next cycle; q is kept.
- Direction change mid-count takes effect on the same cycle's step. Terminal value T is re-evaluated each cycle.
- en=0: q holds, no tc. The one-shot FSM stays in its current state.
- Latency: every output is registered; input to output is one cycle.

Test Plan:
- WIDTH=4, MODULUS=10, mode=00, up, en=1 from reset: q=0,1..9,0. tc=1 exactly in the cycle q first shows 0 after 9. ovf=1 from then on.
- Same config, down from q=0: next q=9, tc=1, ovf=1. Then clr_ovf=1 -> ovf=0. clr_ovf asserted together with another wrap -> ovf stays 1.
- mode=01, up, load_val=8: q=8,9,9,9. tc high each cycle after the step at 9. Switch up_dn=0 -> q=8.
- mode=10, up: start pulse -> busy=1, q=0..9, then tc=1, DONE, IDLE with q=9, busy=0. ovf stays 0. en=0 mid-RUN freezes q and busy.
- load_val=15 with MODULUS=10 -> q=9. load and boundary step in the same cycle -> q=load value, no tc.
- rst pulsed low asynchronously mid-RUN at q=5 -> q=RESET_VAL, tc/ovf/busy=0 immediately. FSM is IDLE after release.
